// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for a minimal RV32 subset (ADDI, BNE).
// It owns the PC and the instruction register and drives the fetch handshake and ALU controls.
module cpu_sequencer #(
  parameter int unsigned                INSTRUCTION_WIDTH = 32,
  parameter int unsigned                ADDRESS_WIDTH     = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC          = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req,
  output logic [ADDRESS_WIDTH-1:0]     imem_addr,
  input  logic                         imem_ack,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
  output logic [INSTRUCTION_WIDTH-1:0] instr,
  input  logic                         eq,
  input  logic [ADDRESS_WIDTH-1:0]     br_offset,
  output logic                         regwrite,
  output logic [2:0]                   aluctrl,
  output logic                         alusrc,
  output logic [2:0]                   immsrc,
  output logic [ADDRESS_WIDTH-1:0]     pc,
  output logic                         retire,
  output logic                         illegal
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALT
  } state_t;

  state_t state;
  logic   is_bne;

  logic   is_addi_enc;
  logic   is_bne_enc;
  logic   taken;
  logic   misaligned;
  logic [ADDRESS_WIDTH-1:0] target;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;

  assign is_addi_enc = (instr[6:0] == 7'b0010011) && (instr[14:12] == 3'b000);
  assign is_bne_enc  = (instr[6:0] == 7'b1100011) && (instr[14:12] == 3'b001);

  assign pc_plus4   = pc + ADDRESS_WIDTH'(4);
  assign target     = pc + br_offset;
  assign taken      = is_bne && !eq;
  assign misaligned = taken && (target[1:0] != 2'b00);

  // Request is gated by rst so it drops in the very cycle reset is asserted.
  assign imem_req  = (state == FETCH) && !rst;
  assign imem_addr = pc;

  // retire depends on eq sampled during WRITEBACK, so it cannot be registered.
  assign retire = (state == WRITEBACK) && !misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      instr    <= '0;
      illegal  <= 1'b0;
      regwrite <= 1'b0;
      alusrc   <= 1'b0;
      aluctrl  <= '0;
      immsrc   <= '0;
      is_bne   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (is_addi_enc) begin
            is_bne  <= 1'b0;
            alusrc  <= 1'b1;
            aluctrl <= 3'b000;
            immsrc  <= 3'b000;
            state   <= EXECUTE;
          end else if (is_bne_enc) begin
            is_bne  <= 1'b1;
            alusrc  <= 1'b0;
            aluctrl <= 3'b001;
            immsrc  <= 3'b010;
            state   <= EXECUTE;
          end else begin
            illegal <= 1'b1;
            state   <= HALT;
          end
        end
        EXECUTE: begin
          regwrite <= !is_bne;
          state    <= WRITEBACK;
        end
        WRITEBACK: begin
          regwrite <= 1'b0;
          alusrc   <= 1'b0;
          aluctrl  <= '0;
          immsrc   <= '0;
          if (misaligned) begin
            illegal <= 1'b1;
            state   <= HALT;
          end else begin
            pc    <= taken ? target : pc_plus4;
            state <= FETCH;
          end
        end
        HALT: state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: fetch handshake, ADDI/BNE sequencing, halts and resets.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        eq;
  logic [31:0] br_offset;
  logic        regwrite;
  logic [2:0]  aluctrl;
  logic        alusrc;
  logic [2:0]  immsrc;
  logic [31:0] pc;
  logic        retire;
  logic        illegal;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] mpc;
  logic [31:0] ir_m;

  localparam logic [31:0] ADDI1 = 32'h0050_0093;
  localparam logic [31:0] ADDI2 = 32'h00A0_0113;
  localparam logic [31:0] BNE   = 32'h0020_9463;
  localparam logic [31:0] BAD   = 32'h0000_0033;
  localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

  cpu_sequencer #(
    .INSTRUCTION_WIDTH(32),
    .ADDRESS_WIDTH    (32),
    .RESET_PC         (32'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .instr     (instr),
    .eq        (eq),
    .br_offset (br_offset),
    .regwrite  (regwrite),
    .aluctrl   (aluctrl),
    .alusrc    (alusrc),
    .immsrc    (immsrc),
    .pc        (pc),
    .retire    (retire),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] word, input int unsigned waits);
    for (int unsigned i = 0; i < waits; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = JUNK;
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, mpc);
      check("wait_ir", instr, ir_m);
      tick();
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, mpc);
    tick();
    imem_ack   = 1'b0;
    imem_rdata = JUNK;
    ir_m       = word;
  endtask

  // Runs one instruction from FETCH; eq is driven inverted during EXECUTE so only the WRITEBACK value matters.
  task automatic run_instr(input logic [31:0] word, input int unsigned waits,
                           input logic e, input logic [31:0] off, output logic halted);
    logic        a, b, bad;
    logic [31:0] tgt;
    halted = 1'b0;
    fetch(word, waits);
    a = (word[6:0] == 7'h13) && (word[14:12] == 3'd0);
    b = (word[6:0] == 7'h63) && (word[14:12] == 3'd1);
    check("dec_instr", instr, word);
    check("dec_req", imem_req, 0);
    check("dec_alusrc", alusrc, 0);
    check("dec_retire", retire, 0);
    if (!a && !b) begin
      tick();
      check("ill_flag", illegal, 1);
      check("ill_req", imem_req, 0);
      check("ill_pc", pc, mpc);
      halted = 1'b1;
      return;
    end
    tick();
    eq        = !e;
    br_offset = off;
    check("ex_alusrc", alusrc, a);
    check("ex_aluctrl", aluctrl, b ? 3'd1 : 3'd0);
    check("ex_immsrc", immsrc, b ? 3'd2 : 3'd0);
    check("ex_regwrite", regwrite, 0);
    check("ex_retire", retire, 0);
    tick();
    eq  = e;
    #1;
    tgt = (b && !e) ? mpc + off : mpc + 32'd4;
    bad = b && !e && (tgt[1:0] != 2'b00);
    check("wb_alusrc", alusrc, a);
    check("wb_aluctrl", aluctrl, b ? 3'd1 : 3'd0);
    check("wb_regwrite", regwrite, a);
    check("wb_retire", retire, !bad);
    check("wb_pc", pc, mpc);
    tick();
    check("post_regwrite", regwrite, 0);
    check("post_retire", retire, 0);
    check("post_aluctrl", aluctrl, 0);
    if (bad) begin
      check("mis_illegal", illegal, 1);
      check("mis_pc", pc, mpc);
      check("mis_req", imem_req, 0);
      halted = 1'b1;
    end else begin
      check("post_pc", pc, tgt);
      check("post_req", imem_req, 1);
      mpc = tgt;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_pc", pc, 0);
    check("rst_ir", instr, 0);
    check("rst_illegal", illegal, 0);
    check("rst_retire", retire, 0);
    check("rst_regwrite", regwrite, 0);
    tick();
    rst  = 1'b0;
    mpc  = 32'h0;
    ir_m = 32'h0;
    #1;
    check("rel_req", imem_req, 1);
    check("rel_addr", imem_addr, 0);
  endtask

  initial begin
    logic h;
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = JUNK;
    eq         = 1'b0;
    br_offset  = 32'h0;
    mpc        = 32'h0;
    ir_m       = 32'h0;
    tick();
    do_reset();

    // ADDI, zero wait: pc 0 -> 4
    run_instr(ADDI1, 0, 1'b0, 32'h0, h);
    check("addi_pc", pc, 32'h4);

    // ADDI with 3 wait cycles; a stray ack in DECODE must be ignored
    fetch(ADDI2, 3);
    imem_ack   = 1'b1;
    imem_rdata = ADDI1;
    tick();
    imem_ack   = 1'b0;
    check("stray_ack_ir", instr, ADDI2);
    tick();
    check("wait_wb_regwrite", regwrite, 1);
    check("wait_wb_retire", retire, 1);
    tick();
    mpc = 32'h8;
    check("wait_pc", pc, 32'h8);

    run_instr(ADDI1, 0, 1'b0, 32'h0, h);
    run_instr(ADDI1, 1, 1'b0, 32'h0, h);
    check("pc_at_10", pc, 32'h10);

    run_instr(BNE, 0, 1'b0, 32'h8, h);
    check("bne_taken_pc", pc, 32'h18);
    run_instr(BNE, 0, 1'b1, 32'h8, h);
    check("bne_nt_pc", pc, 32'h1C);
    run_instr(BNE, 2, 1'b0, 32'hFFFF_FFE0, h);
    check("bne_back_pc", pc, 32'hFFFF_FFFC);
    run_instr(ADDI1, 0, 1'b0, 32'h0, h);
    check("wrap_pc", pc, 32'h0);

    // Taken branch to a misaligned target halts without retiring
    run_instr(BNE, 0, 1'b0, 32'h2, h);
    check("mis_halted", h, 1);
    for (int unsigned i = 0; i < 3; i++) begin
      imem_ack = 1'b1;
      tick();
      check("halt_pc", pc, 32'h0);
      check("halt_req", imem_req, 0);
      check("halt_retire", retire, 0);
      check("halt_illegal", illegal, 1);
    end
    imem_ack = 1'b0;
    do_reset();

    // Illegal encoding
    run_instr(BAD, 0, 1'b0, 32'h0, h);
    check("bad_halted", h, 1);
    for (int unsigned i = 0; i < 3; i++) begin
      imem_ack = 1'b1;
      tick();
      check("bad_hold_req", imem_req, 0);
      check("bad_hold_regwrite", regwrite, 0);
      check("bad_hold_pc", pc, 32'h0);
    end
    imem_ack = 1'b0;
    do_reset();

    // Reset during a fetch wait: request drops at once, pc back to 0
    run_instr(ADDI1, 0, 1'b0, 32'h0, h);
    check("pre_rst_pc", pc, 32'h4);
    tick();
    check("fw_req", imem_req, 1);
    rst = 1'b1;
    #1;
    check("fw_rst_req", imem_req, 0);
    check("fw_rst_pc", pc, 32'h0);
    check("fw_rst_retire", retire, 0);
    tick();
    rst  = 1'b0;
    mpc  = 32'h0;
    ir_m = 32'h0;
    #1;

    // Reset in WRITEBACK abandons the register write and PC update
    fetch(ADDI1, 0);
    tick();
    tick();
    check("wbrst_pre_regwrite", regwrite, 1);
    rst = 1'b1;
    #1;
    check("wbrst_regwrite", regwrite, 0);
    check("wbrst_retire", retire, 0);
    check("wbrst_pc", pc, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("wbrst_after_pc", pc, 32'h0);
    check("wbrst_after_req", imem_req, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have parameter INSTRUCTION_WIDTH, default 32, giving the instruction word width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 32, giving the PC, offset and instruction-memory address width.
REQ-003 The block SHALL have parameter RESET_PC, default 0, giving the PC value loaded on reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-007 The block SHALL have port imem_addr, output, ADDRESS_WIDTH bits: fetch address, equal to pc.
REQ-008 The block SHALL have port imem_ack, input, 1 bit: fetch complete; imem_rdata is valid in the same cycle.
REQ-009 The block SHALL have port imem_rdata, input, INSTRUCTION_WIDTH bits: fetched instruction word.
REQ-010 The block SHALL have port instr, output, INSTRUCTION_WIDTH bits: latched instruction register (IR) driving the datapath.
REQ-011 The block SHALL have port eq, input, 1 bit: ALU zero flag, high when operand 1 equals operand 2.
REQ-012 The block SHALL have port br_offset, input, ADDRESS_WIDTH bits: sign-extended branch offset from the sign extender.
REQ-013 The block SHALL have port regwrite, output, 1 bit: register-file write enable.
REQ-014 The block SHALL have port aluctrl, output, 3 bits: ALU opcode.
REQ-015 The block SHALL have port alusrc, output, 1 bit: ALU operand 2 select (1 = immediate, 0 = register).
REQ-016 The block SHALL have port immsrc, output, 3 bits: sign-extend format select.
REQ-017 The block SHALL have port pc, output, ADDRESS_WIDTH bits: program counter.
REQ-018 The block SHALL have port retire, output, 1 bit: one-cycle pulse when an instruction completes.
REQ-019 The block SHALL have port illegal, output, 1 bit: sticky flag, set when the block halts.

Function
REQ-020 The FSM SHALL have the states FETCH, DECODE, EXECUTE, WRITEBACK and HALT, and each non-HALT state except FETCH SHALL last exactly one cycle.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr = pc, both held stable until the cycle in which imem_ack = 1.
REQ-022 On imem_ack = 1 in FETCH, IR SHALL load imem_rdata and the next state SHALL be DECODE; an imem_ack outside FETCH SHALL be ignored.
REQ-023 In DECODE, {IR[6:0], IR[14:12]} = 0010011_000 SHALL classify as ADDI and 1100011_001 SHALL classify as BNE.
REQ-024 In DECODE, any other encoding SHALL go to HALT; DECODE otherwise SHALL go to EXECUTE.
REQ-025 In EXECUTE and WRITEBACK, ADDI SHALL drive alusrc = 1, aluctrl = 000, immsrc = 000.
REQ-026 In EXECUTE and WRITEBACK, BNE SHALL drive alusrc = 0, aluctrl = 001 (subtract), immsrc = 010.
REQ-027 In all other states, alusrc, aluctrl and immsrc SHALL be 0.
REQ-028 regwrite SHALL be 1 only in the WRITEBACK cycle of ADDI.
REQ-029 In WRITEBACK, ADDI SHALL update pc to pc + 4.
REQ-030 In WRITEBACK, BNE SHALL update pc to pc + br_offset when eq = 0 and to pc + 4 when eq = 1, with eq sampled in that cycle.
REQ-031 All PC arithmetic SHALL be modulo 2^ADDRESS_WIDTH (wrap-around, no flag).
REQ-032 A taken branch whose target has bits [1:0] != 0 SHALL leave pc unchanged and go to HALT.
REQ-033 WRITEBACK SHALL assert retire for that one cycle and go to FETCH, except when REQ-032 applies, in which case retire SHALL stay 0.
REQ-034 On entry to HALT, illegal SHALL be set to 1.
REQ-035 In HALT, imem_req, regwrite and retire SHALL be 0 and pc SHALL be frozen until reset.
REQ-036 Latency SHALL be 3 + (fetch wait cycles + 1) cycles per instruction, i.e. 4 cycles with a zero-wait memory.

Reset
REQ-037 While rst = 1, asynchronously, the state SHALL be FETCH and pc = RESET_PC.
REQ-038 While rst = 1, IR, illegal, retire and regwrite SHALL be 0.
REQ-039 While rst = 1, imem_req SHALL be forced to 0 regardless of state.
REQ-040 A reset asserted mid-fetch, or in any other state, SHALL abandon the instruction without a register write or PC update.
REQ-041 On the first clock edge after rst falls, fetch SHALL begin at RESET_PC.

Verification
REQ-042 ADDI with zero-wait memory: imem_rdata = 0x00500093 with immediate ack -> regwrite high in cycle 4 only, retire pulse, pc 0 -> 4.
REQ-043 BNE taken: 0x00209463 with eq = 0 and br_offset = 8 at pc 0x10 -> pc = 0x18, regwrite stays 0.
REQ-044 BNE not taken: same instruction with eq = 1 -> pc = 0x14, retire pulses.
REQ-045 Memory wait: imem_ack withheld for 3 cycles -> imem_req and imem_addr stable for 4 cycles, IR loaded only on ack.
REQ-046 Illegal instruction: 0x00000033 fetched -> HALT, illegal = 1, imem_req = 0 thereafter; rst then restarts at RESET_PC with illegal = 0.
REQ-047 Wrap and reset: pc = 0xFFFFFFFC with ADDI -> pc = 0; rst asserted during a fetch wait -> imem_req drops in the same cycle, no retire.
